apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that drives the bus toward APB register peripherals such as the 5-register control block (word index 0–4 valid, index > 4 answered with PSLVERR). Accepts one command at a time on a simple valid/ready command port, runs the APB SETUP → ACCESS sequence, waits on PREADY, and returns read data and error status on a one-cycle response strobe. It sits between the team's bus-test sequencer (or a CPU-side bridge) and the APB peripheral bus.

## Interface
- ADDR_W, 32, paddr / cmd_addr width
- DATA_W, 32, pwdata / prdata width
- TIMEOUT, 16, max ACCESS cycles with pready=0 before abort (used only with APB_MASTER_TIMEOUT_EN)
- pclk  in  1  bus clock, all state changes on rising edge
- presetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_slverr  out  1  transfer ended with error
- rsp_timeout  out  1  transfer aborted by watchdog
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  completer ready
- prdata  in  DATA_W  completer read data
- pslverr  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state IDLE.
- IDLE: cmd_ready=1 (decoded from state). On handshake: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, go SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0; unconditionally → ACCESS.
- ACCESS: psel=1, penable=1; stay while pready=0; on pready=1 → IDLE, psel=0, penable=0.
- Completion edge: rsp_valid=1 for exactly one cycle; rsp_slverr=pslverr; rsp_rdata=prdata if read, 0 if write; rsp_timeout=0.
- pslverr/prdata sampled only on the edge where ACCESS && pready; ignored otherwise.
- pwrite/paddr/pwdata held stable from SETUP through end of ACCESS and retain last values in IDLE.
- rsp_rdata/rsp_slverr/rsp_timeout hold last value until next completion.
- cmd_valid while not IDLE: ignored, no queuing.
- All outputs registered except cmd_ready.

## Timing
- Reset (async assert): psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, state IDLE; cmd_ready=1 once presetn deasserted.
- Zero-wait-state transfer: handshake at edge N; psel=1 after N; penable=1 after N+1; pready sampled at N+2; rsp_valid=1 during cycle after N+2; cmd_ready=1 same cycle.
- Each pready=0 cycle in ACCESS adds one cycle latency.
- Back-to-back: new handshake allowed in the same cycle rsp_valid is high; next SETUP one cycle later (3 cycles/transfer min).
- Reset mid-transfer: psel/penable drop asynchronously, no rsp_valid is generated, pending command lost.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter cleared on entry to ACCESS, increments each ACCESS cycle with pready=0; when count reaches TIMEOUT with pready still 0, transfer aborts: → IDLE, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. pready=1 on that same edge wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout constant 0.

## Test plan
- Write 0xDEADBEEF to addr 2, pready=1 zero-wait -> psel high 2 cycles, penable 1 cycle, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
- Read addr 2 with prdata=0xDEADBEEF, pready delayed 3 cycles -> paddr/pwrite stable throughout, rsp_valid 6 cycles after accept, rsp_rdata=0xDEADBEEF.
- Read addr 7, completer returns pslverr=1 with pready=1 -> rsp_slverr=1, rsp_valid one cycle; pslverr=1 pulsed while pready=0 earlier -> ignored.
- Back-to-back writes to addr 0,1,4 with cmd_valid held high -> accepts every 3 cycles, cmd_ready=0 during SETUP/ACCESS, three rsp_valid pulses.
- presetn low during ACCESS -> psel/penable 0 immediately, no rsp_valid; after release next command completes normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=16, pready held 0 -> abort after 16 ACCESS cycles: rsp_valid=1, rsp_slverr=1, rsp_timeout=1; without macro, bus stays in ACCESS.

Source files
------------

// File: rtl/apb_master_if.sv
// apb_master_if: command/response and APB bus bundle for apb_master.
//   cmd_*  : valid/ready command port (requester -> master)
//   rsp_*  : one-cycle completion strobe with read data and status
//   p*     : APB requester signals toward the completer
// modport master : the apb_master view
// modport slave  : the requester + APB completer view
interface apb_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Accepts one command on bus.cmd_*, runs SETUP -> ACCESS, waits on pready,
// and reports read data / error on a one-cycle bus.rsp_valid strobe.
// Ports:
//   pclk     : bus clock, rising edge
//   presetn  : asynchronous active-low reset
//   bus      : apb_master_if.master (command, response and APB signals)
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT cycles of pready=0 (rsp_slverr=1, rsp_timeout=1).
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_slverr;
    logic              r_rsp_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    // Counts completed pready=0 ACCESS cycles; expiry on the TIMEOUT-th one.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

    // Transfer sequencing and all registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            r_cnt         <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_pwrite <= bus.cmd_write;
                        r_paddr  <= bus.cmd_addr;
                        r_pwdata <= bus.cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                ACCESS: begin
                    // pready on the expiry edge still completes normally
                    if (bus.pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_slverr  <= bus.pslverr;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (w_expire) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Ready is decoded from state so a new command can land on the response cycle
    assign bus.cmd_ready   = (r_state == IDLE);
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected responses,
// a monitor pops and compares on rsp_valid, a completer model answers APB.
module tb_apb_master;
    localparam int unsigned TIMEOUT = 16;

    logic pclk;
    logic presetn;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    int unsigned wq[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] model_mem [0:4] = '{default: 32'h0};
    logic [31:0] cmem      [0:4] = '{default: 32'h0};

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // APB completer: 5 registers, index > 4 errors; waits come from wq
    int unsigned wleft = 0;
    bit          acc_active = 1'b0;
    always @(negedge pclk) begin
        if (presetn && bus.psel && bus.penable) begin
            if (!acc_active) begin
                acc_active = 1'b1;
                if (wq.size() > 0) wleft = wq.pop_front();
                else wleft = 0;
            end
            if (wleft > 0) begin
                wleft--;
                bus.pready  = 1'b0;
                bus.pslverr = 1'b1;
                bus.prdata  = $urandom;
            end else begin
                bus.pready = 1'b1;
                acc_active = 1'b0;
                if (bus.paddr > 32'd4) begin
                    bus.pslverr = 1'b1;
                    bus.prdata  = 32'hBAD0_0000 | bus.paddr;
                end else begin
                    bus.pslverr = 1'b0;
                    if (bus.pwrite) begin
                        bus.prdata = $urandom;
                        cmem[bus.paddr[2:0]] = bus.pwdata;
                    end else begin
                        bus.prdata = cmem[bus.paddr[2:0]];
                    end
                end
            end
        end else begin
            acc_active  = 1'b0;
            bus.pready  = 1'($urandom_range(0, 1));
            bus.pslverr = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
        end
    end

    // Monitor: response scoreboard, bus stability and hold checks
    int unsigned psel_cnt = 0, pen_cnt = 0;
    bit          prev_setup = 1'b0;
    logic [31:0] last_rdata = 0;
    logic        last_slverr = 0, last_timeout = 0;
    always @(negedge pclk) begin
        if (!presetn) begin
            psel_cnt = 0; pen_cnt = 0; prev_setup = 1'b0;
            last_rdata = 0; last_slverr = 0; last_timeout = 0;
        end else begin
            if (prev_setup) check("setup_to_access", {62'b0, bus.psel, bus.penable}, 64'd3);
            prev_setup = bus.psel && !bus.penable;
            if (bus.penable && !bus.psel) check("penable_without_psel", 1, 0);
            if (bus.psel) begin
                psel_cnt++;
                if (bus.penable) pen_cnt++;
                check("cmd_ready_busy", bus.cmd_ready, 0);
                if (sb.size() > 0) begin
                    check("paddr_stable", bus.paddr, sb[0].addr);
                    check("pwrite_stable", bus.pwrite, sb[0].write);
                    check("pwdata_stable", bus.pwdata, sb[0].wdata);
                end
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_slverr", bus.rsp_slverr, e.slverr);
                    check("rsp_timeout", bus.rsp_timeout, e.timeout);
                    check("rsp_latency", cyc - e.acc, e.lat);
                    check("psel_cycles", psel_cnt, e.lat);
                    check("penable_cycles", pen_cnt, e.lat - 1);
                end
                psel_cnt = 0; pen_cnt = 0;
                last_rdata = bus.rsp_rdata;
                last_slverr = bus.rsp_slverr;
                last_timeout = bus.rsp_timeout;
            end else begin
                check("rsp_hold", {bus.rsp_rdata, 30'b0, bus.rsp_slverr, bus.rsp_timeout},
                      {last_rdata, 30'b0, last_slverr, last_timeout});
            end
        end
    end

    // Issue one command from a negedge; expectation computed from the rules
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int unsigned waits, input bit to, output int unsigned acc);
        exp_t e;
        int   n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        e.write = w; e.addr = a; e.wdata = d; e.timeout = to;
        if (to) begin
            e.rdata = 0; e.slverr = 1'b1; e.lat = 2 + TIMEOUT - 1;
        end else begin
            e.lat = 2 + waits;
            e.slverr = (a > 32'd4);
            if (w) begin
                e.rdata = 0;
                if (a <= 32'd4) model_mem[a] = d;
            end else begin
                e.rdata = (a <= 32'd4) ? model_mem[a] : (32'hBAD0_0000 | a);
            end
        end
        while (!bus.cmd_ready && n < 100) begin
            @(negedge pclk);
            n++;
        end
        acc = 0;
        if (!bus.cmd_ready) begin
            check("cmd_accept", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        acc = e.acc;
        sb.push_back(e);
        wq.push_back(waits);
        @(negedge pclk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(negedge pclk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned a0, a1, a2, n;
        presetn = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr = 0; bus.cmd_wdata = 0;
        #2;
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_flags", {bus.rsp_slverr, bus.rsp_timeout}, 0);
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("cmd_ready_after_reset", bus.cmd_ready, 1);

        // Zero-wait write, delayed read, error read with early pslverr
        issue(1'b1, 32'd2, 32'hDEADBEEF, 0, 1'b0, a0); bus.cmd_valid = 1'b0; drain();
        issue(1'b0, 32'd2, 32'h0, 3, 1'b0, a0);        bus.cmd_valid = 1'b0; drain();
        check("read_back", bus.rsp_rdata, 32'hDEADBEEF);
        issue(1'b0, 32'd7, 32'h0, 2, 1'b0, a0);        bus.cmd_valid = 1'b0; drain();

        // Back-to-back writes with cmd_valid held
        issue(1'b1, 32'd0, 32'h1111_0000, 0, 1'b0, a0);
        issue(1'b1, 32'd1, 32'h2222_0001, 0, 1'b0, a1);
        issue(1'b1, 32'd4, 32'h4444_0004, 0, 1'b0, a2);
        bus.cmd_valid = 1'b0;
        check("b2b_interval_1", a1 - a0, 3);
        check("b2b_interval_2", a2 - a1, 3);
        drain();

        // Reset during ACCESS
        issue(1'b0, 32'd1, 32'h0, 20, 1'b0, a0);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin @(negedge pclk); n++; end
        check("reached_access", bus.penable, 1);
        #2 presetn = 1'b0;
        #1;
        check("rst_mid_psel", bus.psel, 0);
        check("rst_mid_penable", bus.penable, 0);
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        sb.delete(); wq.delete();
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        issue(1'b0, 32'd1, 32'h0, 1, 1'b0, a0); bus.cmd_valid = 1'b0; drain();

        // Watchdog abort, or indefinite wait when the watchdog is absent
`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'd3, 32'h0, 1000, 1'b1, a0); bus.cmd_valid = 1'b0; drain();
        issue(1'b0, 32'd3, 32'h0, TIMEOUT - 1, 1'b0, a0); bus.cmd_valid = 1'b0; drain();
`else
        issue(1'b0, 32'd3, 32'h0, 1000, 1'b0, a0);
        bus.cmd_valid = 1'b0;
        repeat (40) @(negedge pclk);
        check("stuck_in_access", {bus.psel, bus.penable, bus.rsp_timeout}, 3'b110);
        presetn = 1'b0;
        sb.delete(); wq.delete();
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
`endif

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3), 1'b0, a0);
            if ($urandom_range(0, 2) == 0) begin
                bus.cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge pclk);
            end
        end
        bus.cmd_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
